// File: rtl/packet_inject_arbiter.sv
// Round-robin arbiter sharing one NoC router injection port between NUM_PE
// packetizers, with one-packet-per-PE-per-timestep enforcement.
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   req_valid   : per-PE packet valid            [NUM_PE]
//   req_packet  : per-PE packet, PE i at [i*PW +: PW]
//   req_ready   : per-PE accept (one-hot or zero)
//   out_valid   : registered packet valid toward the router
//   out_packet  : registered packet toward the router [PW]
//   out_ready   : router accept
//   cur_ts      : current timestep bit
//   ts_done     : one-cycle pulse when every PE has injected for cur_ts
//   err_node    : sticky, a granted packet's pe_node did not match its PE

module packet_inject_arbiter #(
    parameter  int FILTER_WIDTH = 8,
    parameter  int NUM_PE       = 4,
    localparam int PW           = 9 + 3 * FILTER_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PE-1:0]    req_valid,
    input  logic [NUM_PE*PW-1:0] req_packet,
    output logic [NUM_PE-1:0]    req_ready,
    output logic                 out_valid,
    output logic [PW-1:0]        out_packet,
    input  logic                 out_ready,
    output logic                 cur_ts,
    output logic                 ts_done,
    output logic                 err_node
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [NUM_PE-1:0] sent_mask;
    logic [1:0]        rr_ptr;

    logic [NUM_PE-1:0] elig;
    logic [3:0]        elig_pad;
    logic              found;
    logic [1:0]        win;
    logic [1:0]        rr_nx;
    logic [PW-1:0]     win_packet;
    logic              accept;
    logic              slot_open;
    logic              grant;
    int                cand;

    // A PE may inject once per timestep, and only a packet stamped
    // with the current timestep.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            elig[i] = req_valid[i] && !sent_mask[i]
                      && (req_packet[i*PW + 5] == cur_ts);
        end
    end

    always_comb begin
        elig_pad               = '0;
        elig_pad[NUM_PE-1:0]   = elig;
    end

    // Round-robin search starting at rr_ptr with wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        rr_nx = '0;
        cand  = 0;
        for (int k = 0; k < NUM_PE; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_PE) begin
                cand = cand - NUM_PE;
            end
            if (!found && elig_pad[2'(cand)]) begin
                found = 1'b1;
                win   = 2'(cand);
                if (cand == NUM_PE - 1) begin
                    rr_nx = '0;
                end else begin
                    rr_nx = 2'(cand + 1);
                end
            end
        end
    end

    always_comb begin
        win_packet = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (win == 2'(i)) begin
                win_packet = req_packet[i*PW +: PW];
            end
        end
    end

    // The output slot can take a new packet when empty, or when the
    // held packet leaves this cycle (zero-bubble hand-off).
    assign out_valid = (state == FULL);
    assign accept    = (state == FULL) && out_ready;
    assign slot_open = (state == EMPTY) || out_ready;
    assign grant     = found && slot_open && !reset;

    assign req_ready = grant ? (NUM_PE'(1) << win) : '0;

    // Completion is counted at router acceptance: the mask is full only
    // after the last PE was granted, and its packet is the one leaving.
    assign ts_done = accept && (&sent_mask) && !reset;

    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: begin
                if (grant) begin
                    state_nx = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_nx = grant ? FULL : EMPTY;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            out_packet <= '0;
            cur_ts     <= 1'b0;
            err_node   <= 1'b0;
            sent_mask  <= '0;
            rr_ptr     <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                out_packet <= win_packet;
                rr_ptr     <= rr_nx;
                if (win_packet[11:10] != win) begin
                    err_node <= 1'b1;
                end
            end
            // A grant cannot coincide with ts_done: the mask is full.
            if (ts_done) begin
                cur_ts    <= ~cur_ts;
                sent_mask <= '0;
            end else if (grant) begin
                sent_mask <= sent_mask | req_ready;
            end
        end
    end

endmodule
